// File: rtl/seq_gen.sv
// Programmable sequence generator: an index register walks a writable lookup table and drives the entry on out_o.
// Optional one-shot mode (oneshot_i / done_o) is enabled with `define SEQ_GEN_ONESHOT_EN.
module seq_gen #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             dir_i,
  input  logic             clear_i,
  input  logic [IW-1:0]    last_idx_i,
  input  logic             wr_en_i,
  input  logic [IW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
`ifdef SEQ_GEN_ONESHOT_EN
  input  logic             oneshot_i,
  output logic             done_o,
`endif
  output logic [WIDTH-1:0] out_o,
  output logic [IW-1:0]    index_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] table_q [DEPTH];
  logic [IW-1:0]    idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [IW-1:0]    last_c;
  logic             step_en_c;

  // Out-of-range last index clamps to the final table entry.
  assign last_c = (32'(last_idx_i) > DEPTH - 1) ? IW'(DEPTH - 1) : last_idx_i;

`ifdef SEQ_GEN_ONESHOT_EN
  logic done_q, done_d;
  assign step_en_c = enable_i && !done_q;
`else
  assign step_en_c = enable_i;
`endif

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
`ifdef SEQ_GEN_ONESHOT_EN
    done_d = done_q;
`endif
    if (clear_i) begin
      idx_d = '0;
`ifdef SEQ_GEN_ONESHOT_EN
      done_d = 1'b0;
`endif
    end else if (step_en_c) begin
      if (!dir_i) begin
        // Also recovers from an index stranded above a freshly lowered last.
        if (idx_q >= last_c) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_d  = last_c;
          wrap_d = 1'b1;
        end else if (idx_q > last_c) begin
          idx_d = last_c;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
`ifdef SEQ_GEN_ONESHOT_EN
      if (wrap_d && oneshot_i) begin
        done_d = 1'b1;
      end
`endif
    end
  end

  // Reset reloads the identity pattern so out_o reads 0 straight away.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        table_q[i] <= WIDTH'(i);
      end
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      if (wr_en_i && (32'(wr_addr_i) < DEPTH)) begin
        table_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

`ifdef SEQ_GEN_ONESHOT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
`endif

  assign out_o   = table_q[idx_q];
  assign index_o = idx_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_seq_gen.sv
// Randomised bench for seq_gen: a power-of-two instance and a DEPTH=6 instance run against a behavioural model.
// Define SEQ_GEN_ONESHOT_EN for both bench and RTL to exercise the one-shot build.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, dir, clear, wr_en, oneshot;
  logic [2:0] last_idx, wr_addr;
  logic [3:0] wr_data;

  logic [2:0] out8;
  logic [3:0] out6;
  logic [2:0] idx8, idx6;
  logic       wrap8, wrap6;
  logic       done8, done6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_gen #(.WIDTH(3), .DEPTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .dir_i(dir), .clear_i(clear),
    .last_idx_i(last_idx), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data[2:0]),
`ifdef SEQ_GEN_ONESHOT_EN
    .oneshot_i(oneshot), .done_o(done8),
`endif
    .out_o(out8), .index_o(idx8), .wrap_o(wrap8)
  );

  seq_gen #(.WIDTH(4), .DEPTH(6)) u_dut6 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .dir_i(dir), .clear_i(clear),
    .last_idx_i(last_idx), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
`ifdef SEQ_GEN_ONESHOT_EN
    .oneshot_i(oneshot), .done_o(done6),
`endif
    .out_o(out6), .index_o(idx6), .wrap_o(wrap6)
  );

`ifndef SEQ_GEN_ONESHOT_EN
  assign done8 = 1'b0;
  assign done6 = 1'b0;
`endif

  // Behavioural reference, one slot per instance
  int dep [2] = '{8, 6};
  int wid [2] = '{3, 4};
  int m_idx [2];
  int m_wrap [2];
  int m_done [2];
  int m_tab [2][8];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
      for (int i = 0; i < 8; i++) m_tab[k][i] = i % (1 << wid[k]);
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      int lst, nxt, w;
      int os;
      lst = (int'(last_idx) > dep[k] - 1) ? dep[k] - 1 : int'(last_idx);
`ifdef SEQ_GEN_ONESHOT_EN
      os = int'(oneshot);
`else
      os = 0;
`endif
      if (wr_en && int'(wr_addr) < dep[k]) m_tab[k][wr_addr] = int'(wr_data) % (1 << wid[k]);
      if (clear) begin
        m_idx[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
      end else if (enable && m_done[k] == 0) begin
        if (!dir) begin
          if (m_idx[k] > lst) begin nxt = 0; w = 1; end
          else begin nxt = (m_idx[k] + 1) % (lst + 1); w = (nxt == 0) ? 1 : 0; end
        end else begin
          if (m_idx[k] > lst) begin nxt = lst; w = 0; end
          else begin nxt = (m_idx[k] + lst) % (lst + 1); w = (m_idx[k] == 0) ? 1 : 0; end
        end
        m_idx[k] = nxt; m_wrap[k] = w;
        if (w == 1 && os == 1) m_done[k] = 1;
      end else begin
        m_wrap[k] = 0;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "/out8"},  out8,  m_tab[0][m_idx[0]]);
    check({tag, "/idx8"},  idx8,  m_idx[0]);
    check({tag, "/wrap8"}, wrap8, m_wrap[0]);
    check({tag, "/out6"},  out6,  m_tab[1][m_idx[1]]);
    check({tag, "/idx6"},  idx6,  m_idx[1]);
    check({tag, "/wrap6"}, wrap6, m_wrap[1]);
`ifdef SEQ_GEN_ONESHOT_EN
    check({tag, "/done8"}, done8, m_done[0]);
    check({tag, "/done6"}, done6, m_done[1]);
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    enable = 0; clear = 0; wr_en = 0; dir = 0;
  endtask

  initial begin
    int vals [7] = '{0, 1, 2, 3, 6, 5, 7};
    int dn [6] = '{4, 3, 2, 1, 0, 4};

    rst = 1; oneshot = 0; last_idx = 0; wr_addr = 0; wr_data = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 0;

    // Load pattern and free-run upward through two passes
    last_idx = 6;
    for (int i = 0; i < 7; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 4'(vals[i]);
      tick("load");
    end
    wr_en = 0; enable = 1;
    for (int i = 0; i < 14; i++) begin
      tick("run_up");
      check("seq_up_out", out8, vals[(i + 1) % 7]);
      check("seq_up_wrap", wrap8, ((i + 1) % 7 == 0) ? 1 : 0);
    end

    // Downward from index 0 with last = 4
    last_idx = 4; dir = 1;
    for (int i = 0; i < 6; i++) begin
      tick("run_dn");
      check("seq_dn_idx", idx8, dn[i]);
      check("seq_dn_wrap", wrap8, (i == 0 || i == 5) ? 1 : 0);
    end

    // last lowered under the index, both directions
    for (int d = 0; d < 2; d++) begin
      idle(); clear = 1; tick("lower_clr");
      clear = 0; enable = 1; last_idx = 7;
      repeat (5) tick("lower_walk");
      last_idx = 2; dir = d[0];
      tick("lower_step");
      check("lower_idx", idx8, (d == 0) ? 0 : 2);
      check("lower_wrap", wrap8, (d == 0) ? 1 : 0);
    end

    // Write the selected entry with stepping paused; DEPTH=6 ignores addr 6/7
    idle(); clear = 1; tick("wr_clr");
    clear = 0; enable = 1; last_idx = 7;
    repeat (3) tick("wr_walk");
    enable = 0; wr_en = 1; wr_addr = 3; wr_data = 4'b0101;
    tick("wr_cur");
    check("wr_cur_out", out8, 5);
    wr_addr = 6; wr_data = 4'hF;
    tick("wr_oob6");
    wr_en = 0;

    // Clear beats enable at index 4
    idle(); clear = 1; tick("ce_clr");
    clear = 0; enable = 1; last_idx = 7;
    repeat (4) tick("ce_walk");
    clear = 1;
    tick("ce_both");
    check("ce_idx", idx8, 0);
    check("ce_wrap", wrap8, 0);

    // Asynchronous reset mid-cycle
    idle(); enable = 1; repeat (3) tick("ar_walk");
    #2 rst = 1; #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst_out", out8, 0);
    #1 rst = 0;

`ifdef SEQ_GEN_ONESHOT_EN
    idle(); clear = 1; tick("os_clr");
    clear = 0; enable = 1; oneshot = 1; last_idx = 3;
    for (int i = 0; i < 8; i++) begin
      tick("os_run");
      check("os_idx", idx8, (i < 3) ? i + 1 : 0);
      check("os_wrap", wrap8, (i == 3) ? 1 : 0);
      check("os_done", done8, (i >= 3) ? 1 : 0);
    end
    oneshot = 0; tick("os_hold");
    check("os_sticky", done8, 1);
    clear = 1; tick("os_release");
    check("os_cleared", done8, 0);
    clear = 0; tick("os_resume");
    check("os_resume_idx", idx8, 1);
`endif

    // Randomised traffic
    idle(); oneshot = 0;
    for (int n = 0; n < 600; n++) begin
      enable   = ($urandom_range(0, 9) < 7);
      dir      = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 19) == 0);
      wr_en    = ($urandom_range(0, 4) == 0);
      wr_addr  = 3'($urandom);
      wr_data  = 4'($urandom);
      if ($urandom_range(0, 7) == 0) last_idx = 3'($urandom);
      if ($urandom_range(0, 15) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1; #1;
        model_reset();
        compare_all("rnd_rst");
        #1 rst = 0;
      end
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
